// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout, FSM states and redirect payload.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned STALL_WIDTH = 4;
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IF    = 1;
  localparam int unsigned STALL_ID    = 2;
  localparam int unsigned STALL_EX    = 3;

  typedef enum logic [1:0] {BOOT, IDLE, PEND} state_e;

  typedef enum logic [1:0] {RD_NONE, RD_JUMP, RD_INT} rd_type_e;

  typedef struct packed {
    rd_type_e          kind;
    logic [ADDR_W-1:0] addr;
  } redirect_t;

  // Stall vector from the raw requests, before FSM overrides.
  function automatic logic [STALL_WIDTH-1:0] base_stall(input logic full, input logic id);
    logic [STALL_WIDTH-1:0] s;
    s = '0;
    if (full) begin
      s = '1;
    end else if (id) begin
      s[STALL_PC] = 1'b1;
      s[STALL_IF] = 1'b1;
      s[STALL_ID] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_cnt.sv
// Saturating consecutive-stall counter with watchdog compare.
module stall_cnt #(
  parameter int unsigned          TMO_W         = 16,
  parameter logic [TMO_W-1:0]     STALL_TIMEOUT = 16'd1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_any,
  output logic timeout
);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!stall_any) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign timeout = (cnt_q >= STALL_TIMEOUT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests and arbitrates redirects into one flush pulse.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0]      RESET_ADDR    = 32'h0000_0000,
  parameter int unsigned      TMO_W         = 16,
  parameter logic [TMO_W-1:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_from_id_i,
  input  logic                   stall_from_ex_i,
  input  logic                   stall_from_mem_i,
  input  logic                   stall_from_clint_i,
  input  logic                   jump_req_i,
  input  logic [31:0]            jump_addr_i,
  input  logic                   int_assert_i,
  input  logic [31:0]            int_addr_i,
  input  logic                   ifu_ready_i,
  output logic [STALL_WIDTH-1:0] stall_o,
  output logic                   flush_o,
  output logic [31:0]            flush_addr_o,
  output logic [31:0]            stall_cycles_o,
  output logic                   stall_timeout_o
);

  state_e                 state_q, state_d;
  redirect_t              pend_q, pend_d;
  redirect_t              req;
  logic                   full, can_issue;
  logic                   flush_c;
  logic [31:0]            flush_addr_c;
  logic [STALL_WIDTH-1:0] stall_c;
  logic [31:0]            stall_cycles_q;
  logic                   timeout_raw;

  assign full      = stall_from_ex_i | stall_from_mem_i | stall_from_clint_i;
  assign can_issue = ifu_ready_i & ~full;

  // Next-state, pending-redirect update and zero-latency flush generation.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    flush_c      = 1'b0;
    flush_addr_c = '0;
    stall_c      = base_stall(full, stall_from_id_i);
    req          = '{kind: RD_NONE, addr: '0};
    if (int_assert_i) begin
      req = '{kind: RD_INT, addr: int_addr_i};
    end else if (jump_req_i) begin
      req = '{kind: RD_JUMP, addr: jump_addr_i};
    end

    case (state_q)
      BOOT: begin
        if (int_assert_i) begin
          pend_d = '{kind: RD_INT, addr: int_addr_i};
        end
        if (can_issue) begin
          flush_c      = 1'b1;
          flush_addr_c = RESET_ADDR;
          state_d      = (pend_d.kind == RD_INT) ? PEND : IDLE;
        end else begin
          stall_c[STALL_PC] = 1'b1;
          stall_c[STALL_IF] = 1'b1;
          stall_c[STALL_ID] = 1'b1;
        end
      end
      IDLE: begin
        if (req.kind != RD_NONE) begin
          if (can_issue) begin
            flush_c      = 1'b1;
            flush_addr_c = req.addr;
          end else begin
            pend_d  = req;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        stall_c[STALL_PC] = 1'b1;
        stall_c[STALL_IF] = 1'b1;
        stall_c[STALL_ID] = 1'b1;
        if (can_issue) begin
          flush_c = 1'b1;
          if (int_assert_i && pend_q.kind == RD_JUMP) begin
            // Interrupt supersedes the held jump and goes out immediately.
            flush_addr_c = int_addr_i;
            pend_d       = '{kind: RD_NONE, addr: '0};
            state_d      = IDLE;
          end else begin
            flush_addr_c = pend_q.addr;
            if (req.kind != RD_NONE) begin
              pend_d = req;
            end else begin
              pend_d  = '{kind: RD_NONE, addr: '0};
              state_d = IDLE;
            end
          end
        end else if (int_assert_i || (jump_req_i && pend_q.kind == RD_JUMP)) begin
          pend_d = req;
        end
      end
      default: begin
        state_d = BOOT;
        pend_d  = '{kind: RD_NONE, addr: '0};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      pend_q         <= '{kind: RD_NONE, addr: '0};
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      stall_cycles_q <= stall_cycles_q + 32'(stall_c[STALL_PC]);
    end
  end

  stall_cnt #(
    .TMO_W         (TMO_W),
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_any (|stall_c),
    .timeout   (timeout_raw)
  );

  // Everything is held at zero while reset is asserted.
  assign stall_o         = rst_n ? stall_c        : '0;
  assign flush_o         = rst_n & flush_c;
  assign flush_addr_o    = rst_n ? flush_addr_c   : '0;
  assign stall_cycles_o  = rst_n ? stall_cycles_q : '0;
  assign stall_timeout_o = rst_n & timeout_raw;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: flushes checked by a cycle-stamped scoreboard, stalls and counters inline.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_from_id_i, stall_from_ex_i, stall_from_mem_i, stall_from_clint_i;
  logic        jump_req_i, int_assert_i, ifu_ready_i;
  logic [31:0] jump_addr_i, int_addr_i;
  logic [3:0]  stall_o;
  logic        flush_o;
  logic [31:0] flush_addr_o;
  logic [31:0] stall_cycles_o;
  logic        stall_timeout_o;

  pipe_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_from_id_i    (stall_from_id_i),
    .stall_from_ex_i    (stall_from_ex_i),
    .stall_from_mem_i   (stall_from_mem_i),
    .stall_from_clint_i (stall_from_clint_i),
    .jump_req_i         (jump_req_i),
    .jump_addr_i        (jump_addr_i),
    .int_assert_i       (int_assert_i),
    .int_addr_i         (int_addr_i),
    .ifu_ready_i        (ifu_ready_i),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .flush_addr_o       (flush_addr_o),
    .stall_cycles_o     (stall_cycles_o),
    .stall_timeout_o    (stall_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flush monitor: every flush must match the oldest expected entry in cycle and address.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_flush: got none expected %h at cycle %0d", q[0].addr, q[0].cyc);
      void'(q.pop_front());
    end
    if (flush_o === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flush: got %h at cycle %0d expected no flush", flush_addr_o, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.addr !== flush_addr_o) begin
          failures++;
          $display("FAIL flush: got %h at cycle %0d expected %h at cycle %0d",
                   flush_addr_o, cyc, e.addr, e.cyc);
        end
      end
    end
  end

  // One clock of stimulus; expected flush is queued, stall vector checked mid-cycle.
  task automatic step(input logic rn, input logic id, input logic ex, input logic mem,
                      input logic rdy, input logic jr, input logic [31:0] ja,
                      input logic ia, input logic [31:0] iaddr,
                      input logic [3:0] exp_stall, input logic fl, input logic [31:0] fa);
    @(posedge clk);
    #1;
    rst_n = rn; stall_from_id_i = id; stall_from_ex_i = ex; stall_from_mem_i = mem;
    stall_from_clint_i = 1'b0; ifu_ready_i = rdy;
    jump_req_i = jr; jump_addr_i = ja; int_assert_i = ia; int_addr_i = iaddr;
    if (fl) q.push_back('{cyc, fa});
    @(negedge clk);
    chk("stall_o", 32'(stall_o), 32'(exp_stall));
  endtask

  task automatic idle(input logic [3:0] exp_stall, input logic fl, input logic [31:0] fa);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, exp_stall, fl, fa);
  endtask

  initial begin
    rst_n = 1'b0; stall_from_id_i = 1'b0; stall_from_ex_i = 1'b0; stall_from_mem_i = 1'b0;
    stall_from_clint_i = 1'b0; jump_req_i = 1'b0; jump_addr_i = '0; int_assert_i = 1'b0;
    int_addr_i = '0; ifu_ready_i = 1'b1;

    // Reset: all outputs zero
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0);
      chk("rst_flush", 32'(flush_o), 0);
      chk("rst_cycles", stall_cycles_o, 0);
      chk("rst_timeout", 32'(stall_timeout_o), 0);
    end

    // Boot flush on the first cycle out of reset
    idle(4'b0000, 1, 32'h0);
    chk("boot_cycles", stall_cycles_o, 0);
    idle(4'b0000, 0, 0);

    // Zero-latency jump in IDLE
    step(1, 0, 0, 0, 1, 1, 32'h80, 0, 0, 4'b0000, 1, 32'h80);
    idle(4'b0000, 0, 0);
    chk("cycles_a", stall_cycles_o, 0);

    // Jump under a 3-cycle memory stall, issued in the first free cycle
    step(1, 0, 0, 1, 1, 1, 32'h100, 0, 0, 4'b1111, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
    idle(4'b0111, 1, 32'h100);
    idle(4'b0000, 0, 0);
    chk("cycles_b", stall_cycles_o, 4);

    // Interrupt replaces a pending jump while fetch is busy
    step(1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 4'b0000, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 4'b0111, 0, 0);
    idle(4'b0111, 1, 32'h200);
    idle(4'b0000, 0, 0);
    chk("cycles_c", stall_cycles_o, 6);

    // Interrupt superseding a pending jump issues directly
    step(1, 0, 0, 0, 0, 1, 32'h300, 0, 0, 4'b0000, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 1, 32'h400, 4'b0111, 1, 32'h400);
    idle(4'b0000, 0, 0);
    chk("cycles_d", stall_cycles_o, 7);

    // Jump arriving as pending interrupt issues is re-latched
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h500, 4'b0000, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h600, 0, 0, 4'b0111, 1, 32'h500);
    idle(4'b0111, 1, 32'h600);
    idle(4'b0000, 0, 0);
    chk("cycles_e", stall_cycles_o, 9);

    // Jump never replaces a pending interrupt
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h700, 4'b0000, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h800, 0, 0, 4'b0111, 0, 0);
    idle(4'b0111, 1, 32'h700);
    idle(4'b0000, 0, 0);
    chk("cycles_f", stall_cycles_o, 11);

    // ID-only stall
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0111, 0, 0);
      chk("id_cycles", stall_cycles_o, 32'(11 + k));
    end
    idle(4'b0000, 0, 0);
    chk("cycles_g", stall_cycles_o, 16);

    // Reset mid-PEND drops the jump; interrupt latched in BOOT follows the boot flush
    step(1, 0, 0, 0, 0, 1, 32'hA00, 0, 0, 4'b0000, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h900, 4'b0111, 0, 0);
    chk("boot2_cycles", stall_cycles_o, 0);
    idle(4'b0000, 1, 32'h0);
    idle(4'b0111, 1, 32'h900);
    idle(4'b0000, 0, 0);
    chk("cycles_h", stall_cycles_o, 2);

    // Watchdog: rises on cycle 1025 of a continuous stall, clears after it drops
    for (int k = 1; k <= 1025; k++) begin
      step(1, 0, 1, 0, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
      if (k == 1) chk("tmo_start", 32'(stall_timeout_o), 0);
      if (k == 1024) chk("tmo_1024", 32'(stall_timeout_o), 0);
      if (k == 1025) chk("tmo_1025", 32'(stall_timeout_o), 1);
    end
    idle(4'b0000, 0, 0);
    chk("tmo_drop", 32'(stall_timeout_o), 1);
    idle(4'b0000, 0, 0);
    chk("tmo_clear", 32'(stall_timeout_o), 0);

    idle(4'b0000, 0, 0);
    idle(4'b0000, 0, 0);
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
